// File: rtl/wbc_pkg.sv
// Shared types for the WBC round controller: algorithm modes,
// controller states and the per-mode round-count table.
package wbc_pkg;

   typedef enum logic [2:0] {
      SPN8    = 3'b000,
      SPN16   = 3'b001,
      SPN32   = 3'b010,
      WARX    = 3'b011,
      SPN24   = 3'b100,
      YOROI16 = 3'b101,
      YOROI32 = 3'b110,
      ALG_ILL = 3'b111
   } alg_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   function automatic logic [4:0] round_count(input alg_mode_e m);
      logic [4:0] n;
      n = 5'd0;
      case (m)
         SPN8:    n = 5'd8;
         SPN16:   n = 5'd10;
         SPN32:   n = 5'd12;
         WARX:    n = 5'd10;
         SPN24:   n = 5'd12;
         YOROI16: n = 5'd16;
         YOROI32: n = 5'd16;
         default: n = 5'd1;
      endcase
      return n;
   endfunction

   // Index of the last outer round; 16 rounds still fit in 4 bits.
   function automatic logic [3:0] final_idx(input alg_mode_e m);
      logic [4:0] f;
      f = round_count(m) - 5'd1;
      return f[3:0];
   endfunction

endpackage

// File: rtl/wbc_round_ctrl.sv
// Outer-round sequencer for the WBC block cipher datapath.
// Optional abort input enabled by macro WBC_ROUND_ABORT_EN.
module wbc_round_ctrl
   import wbc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] alg_mode_in,
   input  logic       round_ready,
`ifdef WBC_ROUND_ABORT_EN
   input  logic       abort,
`endif
   output logic [3:0] outer_round,
   output logic [2:0] alg_mode,
   output logic       round_valid,
   output logic       last_round,
   output logic       busy,
   output logic       done,
   output logic       err
);

   state_e     state_q, state_d;
   alg_mode_e  mode_q, mode_d;
   logic [3:0] round_q, round_d;
   logic       err_q, err_d;
   logic       abort_w;
   logic       at_last;

`ifdef WBC_ROUND_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   assign at_last = (round_q == final_idx(mode_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= SPN8;
         round_q <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         round_q <= round_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      round_d = round_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (alg_mode_in == ALG_ILL) begin
                  err_d = 1'b1;
               end else begin
                  mode_d  = alg_mode_e'(alg_mode_in);
                  round_d = 4'd0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // Abort outranks a handshake in the same cycle.
            if (abort_w) begin
               state_d = IDLE;
            end else if (round_ready) begin
               if (at_last) state_d = DONE;
               else         round_d = round_q + 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign outer_round = round_q;
   assign alg_mode    = mode_q;
   assign round_valid = (state_q == RUN);
   assign last_round  = (state_q == RUN) && at_last;
   assign busy        = (state_q == RUN) || (state_q == DONE);
   assign done        = (state_q == DONE);
   assign err         = err_q;

endmodule
